// File: rtl/seq_debug_mailbox_pkg.sv
// Shared constants for the sequencer debug mailbox: register offsets, status
// layout and the command state machine encoding.
package seq_debug_mailbox_pkg;

    localparam int unsigned OFF_ID         = 'h0;
    localparam int unsigned OFF_REQ_CMD    = 'h8;
    localparam int unsigned OFF_CMD_STATUS = 'hC;
    localparam int unsigned OFF_PARAM_BASE = 'h10;

    localparam logic [1:0] STAT_IDLE  = 2'd0;
    localparam logic [1:0] STAT_BUSY  = 2'd1;
    localparam logic [1:0] STAT_DONE  = 2'd2;
    localparam logic [1:0] STAT_ERROR = 2'd3;

    localparam int STAT_OVERRUN_BIT = 2;
    localparam int STAT_TIMEOUT_BIT = 3;
    localparam int STAT_RSP_LSB     = 8;

    localparam logic [7:0] ID_MAGIC = 8'h5D;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_e;

    // ISSUE and WAIT are both reported to the host as BUSY.
    function automatic logic [1:0] state_code(input state_e s);
        case (s)
            S_ISSUE, S_WAIT: return STAT_BUSY;
            S_DONE:          return STAT_DONE;
            S_ERROR:         return STAT_ERROR;
            default:         return STAT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/seq_debug_regfile.sv
// Avalon-side address decode, PARAM storage and registered read mux
// (fixed one-cycle read latency) for the debug mailbox.
module seq_debug_regfile
    import seq_debug_mailbox_pkg::*;
#(
    parameter int unsigned DEBUG_BASE = 'h00015238,
    parameter int          ADDR_WIDTH = 20,
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_PARAMS = 4,
    parameter int unsigned VERSION    = 'h0002
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ADDR_WIDTH-1:0]            avl_address,
    input  logic                             avl_read,
    input  logic                             avl_write,
    input  logic [DATA_WIDTH-1:0]            avl_writedata,
    output logic [DATA_WIDTH-1:0]            avl_readdata,
    output logic                             avl_readdatavalid,
    input  logic                             wr_allow,
    input  logic [DATA_WIDTH-1:0]            req_cmd_word,
    input  logic [DATA_WIDTH-1:0]            status_word,
    output logic                             req_cmd_wr,
    output logic                             status_wr,
    output logic                             param_wr,
    output logic [NUM_PARAMS*DATA_WIDTH-1:0] param_words
);

    localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(DEBUG_BASE);
    localparam logic [ADDR_WIDTH-1:0] WIN_END = ADDR_WIDTH'(OFF_PARAM_BASE + 4 * NUM_PARAMS);

    logic [ADDR_WIDTH-1:0] off;
    logic                  sel_id;
    logic                  sel_req;
    logic                  sel_stat;
    logic                  sel_param;
    logic [3:0]            param_idx;
    logic [DATA_WIDTH-1:0] rdata;

    logic [DATA_WIDTH-1:0] param_q [NUM_PARAMS];
    logic [DATA_WIDTH-1:0] param_d [NUM_PARAMS];
    logic [DATA_WIDTH-1:0] readdata_q;
    logic [DATA_WIDTH-1:0] readdata_d;
    logic                  rvalid_q;
    logic                  rvalid_d;

    // Addresses below the base wrap to large offsets and fall outside the window.
    always_comb begin
        off       = avl_address - BASE;
        sel_id    = (off == ADDR_WIDTH'(OFF_ID));
        sel_req   = (off == ADDR_WIDTH'(OFF_REQ_CMD));
        sel_stat  = (off == ADDR_WIDTH'(OFF_CMD_STATUS));
        sel_param = (off >= ADDR_WIDTH'(OFF_PARAM_BASE)) && (off < WIN_END) && (off[1:0] == 2'b00);
        param_idx = off[5:2] - 4'd4;
    end

    assign req_cmd_wr = avl_write && sel_req;
    assign status_wr  = avl_write && sel_stat;
    assign param_wr   = avl_write && sel_param;

    always_comb begin
        for (int i = 0; i < NUM_PARAMS; i++) begin
            param_d[i] = param_q[i];
            if (param_wr && wr_allow && (param_idx == 4'(i))) begin
                param_d[i] = avl_writedata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (sel_id) begin
            rdata = DATA_WIDTH'({ID_MAGIC, 16'(VERSION)});
        end else if (sel_req) begin
            rdata = req_cmd_word;
        end else if (sel_stat) begin
            rdata = status_word;
        end else if (sel_param) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                if (param_idx == 4'(i)) begin
                    rdata = param_q[i];
                end
            end
        end
        readdata_d = avl_read ? rdata : '0;
        rvalid_d   = avl_read;
    end

    always_comb begin
        param_words = '0;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            param_words[i*DATA_WIDTH +: DATA_WIDTH] = param_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                param_q[i] <= '0;
            end
            readdata_q <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                param_q[i] <= param_d[i];
            end
            readdata_q <= readdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign avl_readdata      = readdata_q;
    assign avl_readdatavalid = rvalid_q;

endmodule

// File: rtl/seq_debug_mailbox.sv
// Debug command mailbox: host stages PARAMs and a command over Avalon-MM, the
// FSM hands it to the sequencer and tracks completion, error and timeout.
module seq_debug_mailbox
    import seq_debug_mailbox_pkg::*;
#(
    parameter int unsigned DEBUG_BASE     = 'h00015238,
    parameter int          ADDR_WIDTH     = 20,
    parameter int          DATA_WIDTH     = 32,
    parameter int          NUM_PARAMS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned VERSION        = 'h0002
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ADDR_WIDTH-1:0]            avl_address,
    input  logic                             avl_read,
    input  logic                             avl_write,
    input  logic [DATA_WIDTH-1:0]            avl_writedata,
    output logic [DATA_WIDTH-1:0]            avl_readdata,
    output logic                             avl_readdatavalid,
    output logic                             avl_waitrequest,
    output logic                             cmd_valid,
    input  logic                             cmd_ready,
    output logic [DATA_WIDTH-1:0]            cmd_code,
    output logic [NUM_PARAMS*DATA_WIDTH-1:0] cmd_params,
    input  logic                             rsp_valid,
    input  logic [7:0]                       rsp_code
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_e                          state_q, state_d;
    logic [DATA_WIDTH-1:0]           cmd_code_q, cmd_code_d;
    logic [NUM_PARAMS*DATA_WIDTH-1:0] cmd_params_q, cmd_params_d;
    logic                            overrun_q, overrun_d;
    logic                            timeout_q, timeout_d;
    logic [7:0]                      rsp_code_q, rsp_code_d;
    logic [TMO_W-1:0]                tmo_cnt_q, tmo_cnt_d;

    logic                            req_cmd_wr;
    logic                            status_wr;
    logic                            param_wr;
    logic [NUM_PARAMS*DATA_WIDTH-1:0] param_words;
    logic [DATA_WIDTH-1:0]           status_word;

    seq_debug_regfile #(
        .DEBUG_BASE (DEBUG_BASE),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_PARAMS (NUM_PARAMS),
        .VERSION    (VERSION)
    ) u_regfile (
        .clk               (clk),
        .reset             (reset),
        .avl_address       (avl_address),
        .avl_read          (avl_read),
        .avl_write         (avl_write),
        .avl_writedata     (avl_writedata),
        .avl_readdata      (avl_readdata),
        .avl_readdatavalid (avl_readdatavalid),
        .wr_allow          (state_q == S_IDLE),
        .req_cmd_word      (cmd_code_q),
        .status_word       (status_word),
        .req_cmd_wr        (req_cmd_wr),
        .status_wr         (status_wr),
        .param_wr          (param_wr),
        .param_words       (param_words)
    );

    always_comb begin
        status_word                   = '0;
        status_word[1:0]              = state_code(state_q);
        status_word[STAT_OVERRUN_BIT] = overrun_q;
        status_word[STAT_TIMEOUT_BIT] = timeout_q;
        status_word[STAT_RSP_LSB +: 8] = rsp_code_q;
    end

    always_comb begin
        state_d      = state_q;
        cmd_code_d   = cmd_code_q;
        cmd_params_d = cmd_params_q;
        overrun_d    = overrun_q;
        timeout_d    = timeout_q;
        rsp_code_d   = rsp_code_q;
        tmo_cnt_d    = tmo_cnt_q;

        if ((req_cmd_wr || param_wr) && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (req_cmd_wr) begin
                    state_d      = S_ISSUE;
                    cmd_code_d   = avl_writedata;
                    cmd_params_d = param_words;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    state_d   = S_WAIT;
                    tmo_cnt_d = TMO_W'(TIMEOUT_CYCLES);
                end
            end
            // A response in the expiry cycle takes priority over the timeout.
            S_WAIT: begin
                if (rsp_valid) begin
                    rsp_code_d = rsp_code;
                    state_d    = (rsp_code == 8'd0) ? S_DONE : S_ERROR;
                end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt_q == '0)) begin
                    state_d   = S_ERROR;
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
                end
            end
            S_DONE, S_ERROR: begin
                if (status_wr) begin
                    state_d   = S_IDLE;
                    overrun_d = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cmd_code_q   <= '0;
            cmd_params_q <= '0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            rsp_code_q   <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cmd_code_q   <= cmd_code_d;
            cmd_params_q <= cmd_params_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
            rsp_code_q   <= rsp_code_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign cmd_valid       = (state_q == S_ISSUE);
    assign cmd_code        = cmd_code_q;
    assign cmd_params      = cmd_params_q;
    assign avl_waitrequest = 1'b0;

endmodule

// File: tb/tb_seq_debug_mailbox.sv
// Bench for seq_debug_mailbox: directed steps followed by randomized command
// transactions checked against a transaction-level model of the mailbox.
module tb_seq_debug_mailbox;

    localparam int AW  = 20;
    localparam int DW  = 32;
    localparam int NP  = 4;
    localparam int TMO = 8;
    localparam logic [AW-1:0] BASE = 20'h15238;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   avl_address;
    logic            avl_read;
    logic            avl_write;
    logic [DW-1:0]   avl_writedata;
    logic [DW-1:0]   avl_readdata;
    logic            avl_readdatavalid;
    logic            avl_waitrequest;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [DW-1:0]   cmd_code;
    logic [NP*DW-1:0] cmd_params;
    logic            rsp_valid;
    logic [7:0]      rsp_code;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_params [NP];
    logic [7:0]  m_rsp;

    always #5 clk = ~clk;

    seq_debug_mailbox #(
        .DEBUG_BASE     ('h00015238),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .NUM_PARAMS     (NP),
        .TIMEOUT_CYCLES (TMO),
        .VERSION        ('h0002)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .avl_address       (avl_address),
        .avl_read          (avl_read),
        .avl_write         (avl_write),
        .avl_writedata     (avl_writedata),
        .avl_readdata      (avl_readdata),
        .avl_readdatavalid (avl_readdatavalid),
        .avl_waitrequest   (avl_waitrequest),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_code          (cmd_code),
        .cmd_params        (cmd_params),
        .rsp_valid         (rsp_valid),
        .rsp_code          (rsp_code)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int off, input logic [31:0] data);
        avl_address   = BASE + AW'(off);
        avl_writedata = data;
        avl_write     = 1'b1;
        tick();
        avl_write     = 1'b0;
    endtask

    task automatic rd_check(input string tag, input int off, input logic [31:0] exp);
        avl_address = BASE + AW'(off);
        avl_read    = 1'b1;
        tick();
        avl_read    = 1'b0;
        check({tag, "_rvalid"}, avl_readdatavalid, 1);
        check(tag, avl_readdata, exp);
    endtask

    function automatic logic [31:0] stat(input logic [1:0] code, input logic ovr,
                                         input logic to, input logic [7:0] rc);
        return {16'h0, rc, 4'h0, to, ovr, code};
    endfunction

    function automatic logic [127:0] pack_params();
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) r[i*32 +: 32] = m_params[i];
        return r;
    endfunction

    initial begin
        logic [31:0]  code;
        logic [31:0]  v;
        logic [127:0] snap;
        logic [31:0]  exp_st;
        logic [7:0]   rc;
        int           d;
        int           w;
        int           k;
        int           j;
        int           kind;
        logic         busy_wr;

        reset = 1'b1; avl_address = '0; avl_read = 1'b0; avl_write = 1'b0;
        avl_writedata = '0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_code = '0;
        for (int i = 0; i < NP; i++) m_params[i] = '0;
        m_rsp = '0;
        repeat (3) tick();
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_code", cmd_code, 0);
        check("rst_cmd_params", cmd_params, 0);
        check("rst_rvalid", avl_readdatavalid, 0);
        check("rst_readdata", avl_readdata, 0);
        check("rst_waitreq", avl_waitrequest, 0);
        reset = 1'b0;
        tick();

        rd_check("id", 'h0, 32'h005D0002);
        check("rvalid_one_cycle", avl_readdatavalid, 1);
        tick();
        check("rvalid_drops", avl_readdatavalid, 0);
        rd_check("status_reset", 'hC, 0);
        rd_check("param0_reset", 'h10, 0);

        // Basic command, ready already high.
        for (int i = 0; i < NP; i++) wr('h10 + 4*i, 32'(i + 1));
        rd_check("param2_rb", 'h18, 3);
        cmd_ready = 1'b1;
        wr('h8, 32'h21);
        check("basic_valid", cmd_valid, 1);
        check("basic_code", cmd_code, 32'h21);
        check("basic_params", cmd_params, 128'h00000004_00000003_00000002_00000001);
        tick();
        check("basic_valid_once", cmd_valid, 0);
        cmd_ready = 1'b0;
        rd_check("basic_busy", 'hC, stat(1, 0, 0, 0));
        rsp_valid = 1'b1; rsp_code = 8'h00; tick(); rsp_valid = 1'b0;
        rd_check("basic_done", 'hC, stat(2, 0, 0, 0));
        rd_check("req_cmd_rb", 'h8, 32'h21);
        wr('hC, 0);
        rd_check("basic_ack", 'hC, 0);

        // Stalled handshake with an overrun attempt.
        wr('h10, 32'h11);
        wr('h8, 32'h21);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) wr('h8, 32'h99);
            else if (i == 5) wr('h14, 32'hFF);
            else tick();
            check("stall_valid", cmd_valid, 1);
            check("stall_code", cmd_code, 32'h21);
        end
        check("stall_params", cmd_params, 128'h00000004_00000003_00000002_00000011);
        rd_check("stall_status", 'hC, stat(1, 1, 0, 0));
        rd_check("stall_param1", 'h14, 2);
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        rsp_valid = 1'b1; rsp_code = 8'h00; tick(); rsp_valid = 1'b0;
        rd_check("stall_done", 'hC, stat(2, 1, 0, 0));
        wr('hC, 0);
        rd_check("stall_ack", 'hC, 0);

        // Timeout boundary: still busy at WAIT entry+8, ERROR at entry+9.
        cmd_ready = 1'b1;
        wr('h8, 32'h30);
        tick();
        cmd_ready = 1'b0;
        repeat (TMO) tick();
        rd_check("tmo_before", 'hC, stat(1, 0, 0, 0));
        rd_check("tmo_expired", 'hC, 32'hB);
        wr('hC, 0);
        rd_check("tmo_ack", 'hC, 0);

        // Response arriving in the expiry cycle.
        cmd_ready = 1'b1;
        wr('h8, 32'h31);
        tick();
        cmd_ready = 1'b0;
        repeat (TMO) tick();
        rsp_valid = 1'b1; rsp_code = 8'h3C; tick(); rsp_valid = 1'b0;
        rd_check("race_status", 'hC, 32'h3C03);
        wr('hC, 0);
        rd_check("race_ack", 'hC, 32'h3C00);

        // Idle-state no-ops and unmapped space.
        rsp_valid = 1'b1; rsp_code = 8'h55; tick(); rsp_valid = 1'b0;
        wr('hC, 32'hFFFF);
        rd_check("idle_ignore", 'hC, 32'h3C00);
        wr('h4, 32'hDEAD);
        rd_check("unmapped_4", 'h4, 0);
        wr('h20, 32'hBEEF);
        rd_check("unmapped_past", 'h20, 0);
        rd_check("unmapped_below", -4, 0);
        rd_check("unaligned", 'h11, 0);

        // Reset while waiting for a response.
        wr('h10, 32'h77);
        cmd_ready = 1'b1;
        wr('h8, 32'h44);
        tick();
        cmd_ready = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        check("rstw_valid", cmd_valid, 0);
        check("rstw_code", cmd_code, 0);
        check("rstw_params", cmd_params, 0);
        rd_check("rstw_status", 'hC, 0);
        rd_check("rstw_param0", 'h10, 0);

        // Randomized transactions against the model.
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    v = $urandom;
                    wr('h10 + 4*i, v);
                    m_params[i] = v;
                end
            end
            if ($urandom_range(0, 1) == 1) wr('h4, $urandom);
            code = $urandom;
            cmd_ready = 1'b0;
            wr('h8, code);
            snap = pack_params();
            check("r_valid", cmd_valid, 1);
            check("r_code", cmd_code, code);
            check("r_params", cmd_params, snap);
            busy_wr = 1'($urandom_range(0, 1));
            if (busy_wr) begin
                k = $urandom_range(0, NP);
                if (k == NP) wr('h8, $urandom);
                else wr('h10 + 4*k, $urandom);
            end
            d = $urandom_range(0, 3);
            repeat (d) tick();
            check("r_hold_valid", cmd_valid, 1);
            check("r_hold_code", cmd_code, code);
            check("r_hold_params", cmd_params, snap);
            cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
            check("r_taken", cmd_valid, 0);
            kind = $urandom_range(0, 2);
            if (kind == 2) begin
                repeat (TMO + 4) tick();
                exp_st = stat(3, busy_wr, 1, m_rsp);
            end else begin
                w = $urandom_range(0, TMO);
                repeat (w) tick();
                rc = (kind == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                rsp_valid = 1'b1; rsp_code = rc; tick(); rsp_valid = 1'b0;
                m_rsp  = rc;
                exp_st = stat((rc == 8'h00) ? 2'd2 : 2'd3, busy_wr, 0, rc);
            end
            rd_check("r_status", 'hC, exp_st);
            j = $urandom_range(0, NP - 1);
            rd_check("r_param", 'h10 + 4*j, m_params[j]);
            wr('hC, $urandom);
            rd_check("r_ack", 'hC, stat(0, 0, 0, m_rsp));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
